vga_sync_monitor: RTL and testbench



---
 rtl/vga_sync_monitor.sv | 169 ++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: measures HSYNC/VSYNC periods, locks onto
// a stable raster and regenerates pixel coordinates for downstream capture.
module vga_sync_monitor #(
  parameter int unsigned H_SYNC_TO_ACT = 144,
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned V_SYNC_TO_ACT = 35,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned LINE_EXP      = 800,
  parameter int unsigned LINE_TOL      = 2,
  parameter int unsigned FRAME_EXP     = 525,
  parameter int unsigned LOCK_FRAMES   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic        o_locked,
  output logic        o_err,
  output logic        o_frame_start,
  output logic        o_active,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic [10:0] o_line_len,
  output logic [9:0]  o_frame_lines
);

  localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [10:0]   H_MAX       = '1;
  localparam logic [9:0]    V_MAX       = '1;
  localparam logic [10:0]   LEN_MIN     = 11'(LINE_EXP - LINE_TOL);
  localparam logic [10:0]   LEN_MAX     = 11'(LINE_EXP + LINE_TOL);
  localparam logic [9:0]    FRAME_LINES = 10'(FRAME_EXP);
  localparam logic [10:0]   H_ACT_LO    = 11'(H_SYNC_TO_ACT);
  localparam logic [10:0]   H_ACT_HI    = 11'(H_SYNC_TO_ACT + H_ACTIVE);
  localparam logic [9:0]    V_ACT_LO    = 10'(V_SYNC_TO_ACT);
  localparam logic [9:0]    V_ACT_HI    = 10'(V_SYNC_TO_ACT + V_ACTIVE);
  localparam logic [GW-1:0] GOOD_LAST   = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state;
  logic [GW-1:0] good_cnt;
  logic        hs_meta, hs_sync, hs_hist;
  logic        vs_meta, vs_sync, vs_hist;
  logic        hs_fall, vs_fall, frame_start;
  logic        vs_pend, line_bad;
  logic [10:0] h_cnt, line_len_next;
  logic [9:0]  v_cnt, frame_lines_next;
  logic        timeout, len_bad, bad_line_now, frame_good, frame_len_bad;
  logic        in_h, in_v;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_meta <= 1'b1;
      hs_sync <= 1'b1;
      hs_hist <= 1'b1;
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_hist <= 1'b1;
    end else begin
      hs_meta <= i_hs;
      hs_sync <= hs_meta;
      hs_hist <= hs_sync;
      vs_meta <= i_vs;
      vs_sync <= vs_meta;
      vs_hist <= vs_sync;
    end
  end

  always_comb begin
    hs_fall          = hs_hist & ~hs_sync;
    vs_fall          = vs_hist & ~vs_sync;
    frame_start      = hs_fall & (vs_pend | vs_fall);
    timeout          = (h_cnt == H_MAX);
    // Saturate so a timed-out line still reports a maximal, out-of-range length
    line_len_next    = timeout ? H_MAX : h_cnt + 11'd1;
    frame_lines_next = (v_cnt == V_MAX) ? V_MAX : v_cnt + 10'd1;
    len_bad          = hs_fall && ((line_len_next < LEN_MIN) || (line_len_next > LEN_MAX));
    bad_line_now     = len_bad | timeout;
    frame_len_bad    = (frame_lines_next != FRAME_LINES);
    frame_good       = !(line_bad | bad_line_now) && !frame_len_bad;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      vs_pend       <= 1'b0;
      line_bad      <= 1'b0;
      o_line_len    <= '0;
      o_frame_lines <= '0;
    end else begin
      if (hs_fall) begin
        h_cnt      <= '0;
        o_line_len <= line_len_next;
      end else if (!timeout) begin
        h_cnt <= h_cnt + 11'd1;
      end

      if (frame_start) begin
        v_cnt         <= '0;
        o_frame_lines <= frame_lines_next;
      end else if (hs_fall && (v_cnt != V_MAX)) begin
        v_cnt <= v_cnt + 10'd1;
      end

      if (frame_start) vs_pend <= 1'b0;
      else if (vs_fall) vs_pend <= 1'b1;

      // Clearing wins: the frame-start line was already folded into frame_good
      if (frame_start) line_bad <= 1'b0;
      else if (bad_line_now) line_bad <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      o_locked <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state)
        SEARCH: begin
          good_cnt <= '0;
          o_locked <= 1'b0;
          if (frame_start) state <= MEASURE;
        end
        MEASURE: begin
          if (timeout) begin
            state    <= SEARCH;
            good_cnt <= '0;
          end else if (frame_start) begin
            if (!frame_good) begin
              good_cnt <= '0;
            end else if (good_cnt == GOOD_LAST) begin
              good_cnt <= good_cnt + GW'(1);
              state    <= LOCKED;
              o_locked <= 1'b1;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end
        end
        LOCKED: begin
          if (bad_line_now || (frame_start && frame_len_bad)) begin
            o_err    <= 1'b1;
            o_locked <= 1'b0;
            good_cnt <= '0;
            state    <= SEARCH;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  always_comb begin
    in_h          = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI);
    in_v          = (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
    o_active      = (state == LOCKED) && in_h && in_v;
    o_frame_start = frame_start;
    o_x           = o_active ? 10'(h_cnt - H_ACT_LO) : '0;
    o_y           = o_active ? 9'(v_cnt - V_ACT_LO) : '0;
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down raster
// (40-clock lines, 20-line frames) so many frames fit in a short run.
module tb_vga_sync_monitor;

  logic        clk = 1'b0;
  logic        i_rst_n, i_hs, i_vs;
  logic        o_locked, o_err, o_frame_start, o_active;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic [10:0] o_line_len;
  logic [9:0]  o_frame_lines;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_SYNC_TO_ACT(8),
    .H_ACTIVE(24),
    .V_SYNC_TO_ACT(3),
    .V_ACTIVE(12),
    .LINE_EXP(40),
    .LINE_TOL(2),
    .FRAME_EXP(20),
    .LOCK_FRAMES(2)
  ) dut (
    .i_clk(clk),
    .i_rst_n(i_rst_n),
    .i_hs(i_hs),
    .i_vs(i_vs),
    .o_locked(o_locked),
    .o_err(o_err),
    .o_frame_start(o_frame_start),
    .o_active(o_active),
    .o_x(o_x),
    .o_y(o_y),
    .o_line_len(o_line_len),
    .o_frame_lines(o_frame_lines)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Each driven cycle c of a line is applied at the negedge preceding edge E_c;
  // the monitor's h_cnt is 0 after E2 and equals c-2 after E_c.
  task automatic drive(input logic hs, input logic vs, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_hs = hs;
      i_vs = vs;
    end
  endtask

  task automatic probe();
    @(posedge clk);
    #1;
  endtask

  task automatic head_a(input logic vs);   // after E1: hs_fall visible
    drive(1'b0, vs, 2);
    probe();
  endtask

  task automatic head_b(input logic vs);   // after E2: hs_fall consumed
    drive(1'b0, vs, 1);
    probe();
  endtask

  task automatic head_rest(input logic vs, input int len);
    drive(1'b0, vs, 1);
    drive(1'b1, vs, len - 4);
  endtask

  task automatic line(input logic vs, input int len);
    head_a(vs);
    head_b(vs);
    head_rest(vs, len);
  endtask

  task automatic lines(input int first, input int last);
    for (int j = first; j <= last; j++) line((j < 2) ? 1'b0 : 1'b1, 40);
  endtask

  task automatic upto(input logic vs, input int k);  // returns with h_cnt == k
    drive(1'b0, vs, 4);
    drive(1'b1, vs, k - 1);
    probe();
  endtask

  task automatic finish_line(input logic vs, input int len, input int k);
    drive(1'b1, vs, len - k - 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0;
    i_hs    = 1'b1;
    i_vs    = 1'b1;
    repeat (3) probe();
    chk("rst_flags", {28'd0, o_locked, o_err, o_frame_start, o_active}, 32'd0);
    chk("rst_x", 32'(o_x), 32'd0);
    chk("rst_y", 32'(o_y), 32'd0);
    chk("rst_line_len", 32'(o_line_len), 32'd0);
    chk("rst_frame_lines", 32'(o_frame_lines), 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    drive(1'b1, 1'b1, 5);

    // F1: coincident vs/hs fall -> first frame start, enter MEASURE
    head_a(1'b0);
    chk("f1_frame_start", 32'(o_frame_start), 32'd1);
    head_b(1'b0);
    chk("f1_frame_start_end", 32'(o_frame_start), 32'd0);
    chk("f1_locked", 32'(o_locked), 32'd0);
    chk("f1_frame_lines", 32'(o_frame_lines), 32'd1);
    head_rest(1'b0, 40);
    lines(1, 19);

    // F2: good_cnt becomes 1
    head_a(1'b0);
    head_b(1'b0);
    chk("f2_locked", 32'(o_locked), 32'd0);
    chk("f2_frame_lines", 32'(o_frame_lines), 32'd20);
    chk("f2_line_len", 32'(o_line_len), 32'd40);
    head_rest(1'b0, 40);
    lines(1, 19);

    // F3: lock, then coordinate boundaries
    head_a(1'b0);
    chk("f3_frame_start", 32'(o_frame_start), 32'd1);
    chk("f3_locked_before", 32'(o_locked), 32'd0);
    head_b(1'b0);
    chk("f3_locked", 32'(o_locked), 32'd1);
    chk("f3_err", 32'(o_err), 32'd0);
    head_rest(1'b0, 40);
    lines(1, 2);
    upto(1'b1, 7);
    chk("h7_active", 32'(o_active), 32'd0);
    chk("h7_x", 32'(o_x), 32'd0);
    drive(1'b1, 1'b1, 1);
    probe();
    chk("h8v3_active", 32'(o_active), 32'd1);
    chk("h8v3_x", 32'(o_x), 32'd0);
    chk("h8v3_y", 32'(o_y), 32'd0);
    finish_line(1'b1, 40, 8);
    lines(4, 13);
    upto(1'b1, 31);
    chk("h31v14_active", 32'(o_active), 32'd1);
    chk("h31v14_x", 32'(o_x), 32'd23);
    chk("h31v14_y", 32'(o_y), 32'd11);
    drive(1'b1, 1'b1, 1);
    probe();
    chk("h32_active", 32'(o_active), 32'd0);
    chk("h32_x", 32'(o_x), 32'd0);
    chk("h32_y", 32'(o_y), 32'd0);
    finish_line(1'b1, 40, 32);
    lines(15, 19);

    // F4: 42-clock line tolerated, 43-clock line breaks lock
    head_a(1'b0);
    head_b(1'b0);
    chk("f4_locked", 32'(o_locked), 32'd1);
    head_rest(1'b0, 40);
    lines(1, 4);
    line(1'b1, 42);
    head_a(1'b1);
    head_b(1'b1);
    chk("len42_line_len", 32'(o_line_len), 32'd42);
    chk("len42_err", 32'(o_err), 32'd0);
    chk("len42_locked", 32'(o_locked), 32'd1);
    head_rest(1'b1, 43);
    head_a(1'b1);
    head_b(1'b1);
    chk("len43_err", 32'(o_err), 32'd1);
    chk("len43_locked", 32'(o_locked), 32'd0);
    chk("len43_line_len", 32'(o_line_len), 32'd43);
    drive(1'b0, 1'b1, 1);
    probe();
    chk("len43_err_pulse_end", 32'(o_err), 32'd0);
    drive(1'b1, 1'b1, 36);
    lines(8, 19);

    // F5..F7: relock; F7 is one line short
    lines(0, 19);
    lines(0, 19);
    head_a(1'b0);
    head_b(1'b0);
    chk("f7_locked", 32'(o_locked), 32'd1);
    head_rest(1'b0, 40);
    lines(1, 18);

    // F8: short frame detected at its closing frame start
    head_a(1'b0);
    head_b(1'b0);
    chk("short_err", 32'(o_err), 32'd1);
    chk("short_locked", 32'(o_locked), 32'd0);
    chk("short_frame_lines", 32'(o_frame_lines), 32'd19);
    head_rest(1'b0, 40);
    lines(1, 19);
    lines(0, 19);
    head_a(1'b0);
    head_b(1'b0);
    chk("f10_locked", 32'(o_locked), 32'd0);
    head_rest(1'b0, 40);
    lines(1, 19);
    head_a(1'b0);
    head_b(1'b0);
    chk("f11_relocked", 32'(o_locked), 32'd1);
    chk("f11_frame_lines", 32'(o_frame_lines), 32'd20);
    head_rest(1'b0, 40);
    lines(1, 4);

    // HSYNC stuck high: h_cnt reaches 2047 after E2049 of line 4
    drive(1'b1, 1'b1, 2010);
    probe();
    chk("to_pre_err", 32'(o_err), 32'd0);
    chk("to_pre_locked", 32'(o_locked), 32'd1);
    drive(1'b1, 1'b1, 1);
    probe();
    chk("to_err", 32'(o_err), 32'd1);
    chk("to_locked", 32'(o_locked), 32'd0);
    drive(1'b1, 1'b1, 1);
    probe();
    chk("to_err_pulse_end", 32'(o_err), 32'd0);

    // VSYNC falls ahead of HSYNC: frame start waits for the next hs_fall
    drive(1'b1, 1'b0, 2);
    probe();
    chk("vs_only_frame_start", 32'(o_frame_start), 32'd0);
    drive(1'b1, 1'b0, 3);
    head_a(1'b0);
    chk("vs_pend_frame_start", 32'(o_frame_start), 32'd1);
    head_b(1'b0);
    head_rest(1'b0, 40);
    lines(1, 19);
    lines(0, 19);
    head_a(1'b0);
    head_b(1'b0);
    chk("f14_relocked", 32'(o_locked), 32'd1);
    chk("f14_frame_lines", 32'(o_frame_lines), 32'd20);
    head_rest(1'b0, 40);
    lines(1, 5);
    upto(1'b1, 12);
    chk("pre_rst_active", 32'(o_active), 32'd1);
    chk("pre_rst_x", 32'(o_x), 32'd4);
    chk("pre_rst_y", 32'(o_y), 32'd3);

    // Asynchronous reset mid-line, checked before any further clock edge
    @(negedge clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_flags", {28'd0, o_locked, o_err, o_frame_start, o_active}, 32'd0);
    chk("arst_x", 32'(o_x), 32'd0);
    chk("arst_y", 32'(o_y), 32'd0);
    chk("arst_line_len", 32'(o_line_len), 32'd0);
    chk("arst_frame_lines", 32'(o_frame_lines), 32'd0);
    drive(1'b1, 1'b1, 3);
    i_rst_n = 1'b1;
    drive(1'b1, 1'b1, 5);
    lines(0, 19);
    head_a(1'b0);
    head_b(1'b0);
    chk("post_rst_f2_locked", 32'(o_locked), 32'd0);
    head_rest(1'b0, 40);
    lines(1, 19);
    head_a(1'b0);
    head_b(1'b0);
    chk("post_rst_f3_locked", 32'(o_locked), 32'd1);
    head_rest(1'b0, 40);
    drive(1'b1, 1'b1, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
